ee354_gcd_arbiter: RTL and testbench

//   Shares one ee354_GCD core among NUM_REQ requesters using round-robin arbitration.

---
 rtl/ee354_gcd_arbiter_pkg.sv | 32 +++
 rtl/ee354_gcd_arbiter_rr_picker.sv | 31 +++
 rtl/ee354_gcd_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ee354_gcd_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ee354_gcd_arbiter_pkg.sv
// Shared definitions for the GCD arbiter slice: arbiter state encoding,
// datapath width, requester index width and a small index helper.
package ee354_gcd_arbiter_pkg;

    // Operand and result width of the shared GCD core.
    localparam int DATA_W = 8;

    // Requester index width. Three bits cover the largest supported NUM_REQ of 8.
    localparam int IDX_W = 3;

    // One-hot arbiter states.
    typedef enum logic [4:0] {
        ARB_IDLE  = 5'b00001,
        ARB_START = 5'b00010,
        ARB_WAIT  = 5'b00100,
        ARB_ACK   = 5'b01000,
        ARB_ZERO  = 5'b10000
    } arb_state_t;

    // (base + offset) mod n, for base < n and offset <= n.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int offset,
                                                  input int n);
        int sum;
        sum = int'(base) + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return IDX_W'(sum);
    endfunction

endpackage

// File: rtl/ee354_gcd_arbiter_rr_picker.sv
// Combinational round-robin picker. Scans Req starting one past the
// last-served pointer and wraps; the first set request wins.
module ee354_rr_picker
    import ee354_gcd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    // Walk the candidates in priority order (ptr+1, ptr+2, ..., ptr) and keep the first hit.
    always_comb begin
        any     = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any && req[j] && (wrap_idx(ptr, i, NUM_REQ) == IDX_W'(j))) begin
                    any       = 1'b1;
                    win_oh[j] = 1'b1;
                    win_idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ee354_gcd_arbiter.sv
// Round-robin front end that shares a single ee354 GCD core among NUM_REQ
// requesters. It latches the winner's operands, drives the core's Start/Ack
// handshake, counts the core's compute cycles and returns Result/Cycles to the
// winner with a one-cycle Done strobe. Zero operands bypass the core entirely.
//
// Handshake summary: a requester raises Req[i] and holds it until it sees
// Done[i]; Done[i] is a single-cycle strobe and Result/Cycles are valid in that
// cycle and held until the next strobe. Toward the core, Core_Start is held
// until the core leaves q_I, and Core_Ack is held for one CEN-enabled cycle
// while the core sits in q_Done.
module ee354_gcd_arbiter
    import ee354_gcd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,  // 2..8
    parameter int CNT_W   = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      CEN,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [DATA_W*NUM_REQ-1:0] Ain_bus,
    input  logic [DATA_W*NUM_REQ-1:0] Bin_bus,
    output logic [NUM_REQ-1:0]        Grant,
    output logic [NUM_REQ-1:0]        Done,
    output logic [DATA_W-1:0]         Result,
    output logic [CNT_W-1:0]          Cycles,
    output logic                      Busy,
    output logic                      Core_Start,
    output logic                      Core_Ack,
    output logic [DATA_W-1:0]         Core_Ain,
    output logic [DATA_W-1:0]         Core_Bin,
    input  logic                      Core_q_I,
    input  logic                      Core_q_Done,
    input  logic [DATA_W-1:0]         Core_GCD,
    output logic [4:0]                State_dbg
);

    arb_state_t           state, next_state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     win_idx;
    logic [CNT_W-1:0]     cnt;

    logic                 pick_any;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic [DATA_W-1:0]    sel_a, sel_b;
    logic                 sel_zero;

    ee354_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (Req),
        .ptr     (ptr),
        .any     (pick_any),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    // Route the candidate winner's operand slices to the latch inputs.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_a = Ain_bus[i*DATA_W +: DATA_W];
                sel_b = Bin_bus[i*DATA_W +: DATA_W];
            end
        end
        sel_zero = (sel_a == '0) || (sel_b == '0);
    end

    // State register; frozen while CEN is low, Reset always wins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ARB_IDLE;
        end else if (CEN) begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore outputs toward the core and requesters.
    always_comb begin
        next_state = state;
        Core_Start = 1'b0;
        Core_Ack   = 1'b0;
        Done       = '0;
        Busy       = (state != ARB_IDLE);
        State_dbg  = state;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    next_state = sel_zero ? ARB_ZERO : ARB_START;
                end
            end
            ARB_START: begin
                Core_Start = 1'b1;
                if (!Core_q_I) begin
                    next_state = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (Core_q_Done) begin
                    next_state = ARB_ACK;
                end
            end
            ARB_ACK: begin
                Core_Ack   = 1'b1;
                next_state = ARB_IDLE;
                if (CEN && !Reset) begin
                    Done = Grant;
                end
            end
            ARB_ZERO: begin
                next_state = ARB_IDLE;
                if (CEN && !Reset) begin
                    Done = Grant;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // Grant, pointer, operand latches, result registers and the compute counter.
    // The counter starts at 1 on the edge that moves us into ARB_WAIT because
    // the core already spent that CEN edge computing after leaving q_I.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr      <= IDX_W'(NUM_REQ - 1);
            win_idx  <= '0;
            Grant    <= '0;
            Result   <= '0;
            Cycles   <= '0;
            cnt      <= '0;
            Core_Ain <= '0;
            Core_Bin <= '0;
        end else if (CEN) begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        win_idx  <= pick_idx;
                        Grant    <= pick_oh;
                        Core_Ain <= sel_a;
                        Core_Bin <= sel_b;
                        if (sel_zero) begin
                            Result <= '0;
                            Cycles <= '0;
                        end
                    end
                end
                ARB_START: begin
                    cnt <= Core_q_I ? '0 : CNT_W'(1);
                end
                ARB_WAIT: begin
                    if (Core_q_Done) begin
                        Result <= Core_GCD;
                        Cycles <= cnt;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ARB_ACK, ARB_ZERO: begin
                    Grant <= '0;
                    ptr   <= win_idx;
                end
                default: begin
                    Grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ee354_gcd_arbiter.sv
// Bench for ee354_gcd_arbiter: a behavioural GCD core stands in for the real
// datapath, Done strobes are logged by a monitor, and each scenario task
// compares the logged results against a modulo-based GCD reference.
module tb_ee354_gcd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 16;
    localparam int BUDGET  = 3000;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 CEN;
    logic [NUM_REQ-1:0]   Req;
    logic [8*NUM_REQ-1:0] Ain_bus, Bin_bus;
    logic [NUM_REQ-1:0]   Grant, Done;
    logic [7:0]           Result;
    logic [CNT_W-1:0]     Cycles;
    logic                 Busy, Core_Start, Core_Ack;
    logic [7:0]           Core_Ain, Core_Bin;
    logic                 Core_q_I, Core_q_Done;
    logic [7:0]           Core_GCD;
    logic [4:0]           State_dbg;

    int vectors    = 0;
    int miscompares = 0;
    int cyc_n      = 0;
    bit cen_div    = 1'b0;

    ee354_gcd_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Req(Req),
        .Ain_bus(Ain_bus), .Bin_bus(Bin_bus),
        .Grant(Grant), .Done(Done), .Result(Result), .Cycles(Cycles),
        .Busy(Busy), .Core_Start(Core_Start), .Core_Ack(Core_Ack),
        .Core_Ain(Core_Ain), .Core_Bin(Core_Bin),
        .Core_q_I(Core_q_I), .Core_q_Done(Core_q_Done), .Core_GCD(Core_GCD),
        .State_dbg(State_dbg)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- behavioural GCD core (subtractive, one step per CEN edge) ----------------
    int         cs    = 0;   // 0 = q_I, 1 = computing, 2 = q_Done
    logic [7:0] ca    = 0, cb = 0, cgcd = 0;
    int         steps = 0;   // CEN edges spent computing for the current operation

    assign Core_q_I    = (cs == 0);
    assign Core_q_Done = (cs == 2);
    assign Core_GCD    = cgcd;

    always @(posedge Clk) begin
        if (Reset) begin
            cs <= 0; ca <= 0; cb <= 0; cgcd <= 0;
        end else if (CEN) begin
            case (cs)
                0: if (Core_Start) begin cs <= 1; ca <= Core_Ain; cb <= Core_Bin; steps <= 0; end
                1: begin
                    steps <= steps + 1;
                    if (ca == cb) begin cgcd <= ca; cs <= 2; end
                    else if (ca > cb) ca <= ca - cb;
                    else cb <= cb - ca;
                end
                2: if (Core_Ack) cs <= 0;
                default: cs <= 0;
            endcase
        end
    end

    // ---------------- monitor: log every Done strobe ----------------
    int         done_cnt  = 0;
    int         start_cnt = 0;
    logic [3:0] log_vec [0:1023];
    logic [7:0] log_res [0:1023];
    logic [15:0] log_cyc [0:1023];

    always @(negedge Clk) begin
        if (|Done) begin
            log_vec[done_cnt % 1024] <= Done;
            log_res[done_cnt % 1024] <= Result;
            log_cyc[done_cnt % 1024] <= Cycles;
            done_cnt <= done_cnt + 1;
        end
        if (Core_Start) start_cnt <= start_cnt + 1;
    end

    // ---------------- reference model ----------------
    function automatic int gcd_ref(input int a, input int b);
        int x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc_n++;
        CEN = cen_div ? (cyc_n % 3 == 0) : 1'b1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Req = '0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        Ain_bus[idx*8 +: 8] = a;
        Bin_bus[idx*8 +: 8] = b;
    endtask

    task automatic wait_done(output bit got);
        int base;
        base = done_cnt;
        got  = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (done_cnt > base) begin got = 1'b1; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1; Req = '1;
        Ain_bus = $urandom; Bin_bus = $urandom;
        repeat (2) tick();
        vectors++;
        if (Grant !== 4'b0 || Done !== 4'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: Grant=%b Done=%b Busy=%b, need 0000 0000 0", Grant, Done, Busy);
        end
        vectors++;
        if (Result !== 8'd0 || Cycles !== 16'd0 || Core_Ain !== 8'd0 || Core_Bin !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_data: Result=%0d Cycles=%0d Ain=%0d Bin=%0d, need all 0", Result, Cycles, Core_Ain, Core_Bin);
        end
        vectors++;
        if (Core_Start !== 1'b0 || Core_Ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_core: Start=%b Ack=%b, need 0 0", Core_Start, Core_Ack);
        end
        Req = '0;
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit got;
        set_ops(0, 8'd36, 8'd24);
        Req = 4'b0001;
        tick();
        vectors++;
        if (Grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL basic_grant: got %b need 0001", Grant);
        end
        wait_done(got);
        Req = '0;
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL basic_timeout: no Done, need one");
        end else begin
            vectors++;
            if (log_vec[(done_cnt-1)%1024] !== 4'b0001 || log_res[(done_cnt-1)%1024] !== 8'd12) begin
                miscompares++;
                $display("FAIL basic_result: Done=%b Result=%0d need 0001 12", log_vec[(done_cnt-1)%1024], log_res[(done_cnt-1)%1024]);
            end
            vectors++;
            if (log_cyc[(done_cnt-1)%1024] !== 16'(steps) || log_cyc[(done_cnt-1)%1024] == 16'd0) begin
                miscompares++;
                $display("FAIL basic_cycles: got %0d need %0d (>0)", log_cyc[(done_cnt-1)%1024], steps);
            end
        end
        tick();
    endtask

    task automatic test_round_robin();
        bit got;
        logic [7:0] a [4];
        logic [7:0] b [4];
        int order [6];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = 8'($urandom_range(1, 200));
            b[i] = 8'($urandom_range(1, 200));
            set_ops(i, a[i], b[i]);
        end
        Req = 4'b1111;
        order = '{0, 1, 2, 3, 0, 3};
        for (int k = 0; k < 6; k++) begin
            if (k == 4) Req = 4'b1001;
            wait_done(got);
            vectors++;
            if (!got) begin
                miscompares++; $display("FAIL rr_timeout: step %0d no Done", k);
            end else begin
                vectors++;
                if (log_vec[(done_cnt-1)%1024] !== 4'(1 << order[k]) ||
                    log_res[(done_cnt-1)%1024] !== 8'(gcd_ref(a[order[k]], b[order[k]]))) begin
                    miscompares++;
                    $display("FAIL rr_order: step %0d Done=%b Result=%0d need %b %0d", k,
                             log_vec[(done_cnt-1)%1024], log_res[(done_cnt-1)%1024],
                             4'(1 << order[k]), gcd_ref(a[order[k]], b[order[k]]));
                end
            end
            Req[order[k]] = 1'b0;
        end
        tick();
    endtask

    task automatic test_zero_bypass();
        int s0, d0;
        s0 = start_cnt;
        d0 = done_cnt;
        set_ops(2, 8'd0, 8'd5);
        Req = 4'b0100;
        tick();
        vectors++;
        if (Done !== 4'b0100 || Grant !== 4'b0100 || Result !== 8'd0 || Cycles !== 16'd0) begin
            miscompares++;
            $display("FAIL zero_bypass: Done=%b Grant=%b Result=%0d Cycles=%0d need 0100 0100 0 0", Done, Grant, Result, Cycles);
        end
        Req = '0;
        repeat (4) tick();
        vectors++;
        if (start_cnt != s0 || done_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL zero_core: starts=%0d dones=%0d need 0 1", start_cnt - s0, done_cnt - d0);
        end
    endtask

    task automatic test_cen_throttle();
        bit got;
        logic [15:0] c_full;
        int d0;
        set_ops(1, 8'd63, 8'd18);
        Req = 4'b0010;
        wait_done(got);
        Req = '0;
        c_full = log_cyc[(done_cnt-1)%1024];
        vectors++;
        if (!got || log_res[(done_cnt-1)%1024] !== 8'd9) begin
            miscompares++;
            $display("FAIL cen_full: got=%0d Result=%0d need 1 9", got, log_res[(done_cnt-1)%1024]);
        end
        tick();
        cen_div = 1'b1;
        d0 = done_cnt;
        Req = 4'b0010;
        wait_done(got);
        Req = '0;
        repeat (12) tick();
        cen_div = 1'b0;
        tick();
        vectors++;
        if (!got || log_res[d0%1024] !== 8'd9 || log_cyc[d0%1024] !== c_full) begin
            miscompares++;
            $display("FAIL cen_slow: got=%0d Result=%0d Cycles=%0d need 1 9 %0d", got, log_res[d0%1024], log_cyc[d0%1024], c_full);
        end
        vectors++;
        if (done_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL cen_strobes: %0d strobes need 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0, n;
        d0 = done_cnt;
        set_ops(2, 8'd200, 8'd3);
        Req = 4'b0100;
        n = 0;
        while (!(cs == 1 && Busy) && n < 50) begin tick(); n++; end
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        vectors++;
        if (Grant !== 4'b0 || Busy !== 1'b0 || Core_Start !== 1'b0 || Core_Ack !== 1'b0 || Done !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_mid: Grant=%b Busy=%b Start=%b Ack=%b Done=%b need all 0", Grant, Busy, Core_Start, Core_Ack, Done);
        end
        Req = '0;
        Reset = 1'b0;
        repeat (5) tick();
        vectors++;
        if (done_cnt != d0) begin
            miscompares++;
            $display("FAIL reset_mid_done: %0d strobes need 0", done_cnt - d0);
        end
    endtask

    task automatic test_req_drop();
        bit got;
        int n;
        set_ops(1, 8'd100, 8'd75);
        Req = 4'b0010;
        n = 0;
        while (cs != 1 && n < 50) begin tick(); n++; end
        tick();
        Req = '0;
        set_ops(1, 8'd7, 8'd3);  // operands changed after grant must not matter
        wait_done(got);
        vectors++;
        if (!got || log_vec[(done_cnt-1)%1024] !== 4'b0010 || log_res[(done_cnt-1)%1024] !== 8'd25) begin
            miscompares++;
            $display("FAIL req_drop: got=%0d Done=%b Result=%0d need 1 0010 25", got,
                     log_vec[(done_cnt-1)%1024], log_res[(done_cnt-1)%1024]);
        end
        tick();
    endtask

    task automatic test_sweep();
        bit got;
        int a, b;
        for (int k = 0; k < 124; k++) begin
            case (k)
                0: begin a = 2;  b = 2;  end
                1: begin a = 63; b = 63; end
                2: begin a = 2;  b = 63; end
                3: begin a = 63; b = 2;  end
                default: begin a = $urandom_range(2, 63); b = $urandom_range(2, 63); end
            endcase
            set_ops(3, 8'(a), 8'(b));
            Req = 4'b1000;
            wait_done(got);
            Req = '0;
            vectors++;
            if (!got || log_vec[(done_cnt-1)%1024] !== 4'b1000 ||
                log_res[(done_cnt-1)%1024] !== 8'(gcd_ref(a, b)) ||
                log_cyc[(done_cnt-1)%1024] !== 16'(steps)) begin
                miscompares++;
                $display("FAIL sweep: A=%0d B=%0d got=%0d Done=%b Result=%0d Cycles=%0d need 1000 %0d %0d", a, b, got,
                         log_vec[(done_cnt-1)%1024], log_res[(done_cnt-1)%1024], log_cyc[(done_cnt-1)%1024],
                         gcd_ref(a, b), steps);
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        Reset = 1'b1; CEN = 1'b1; Req = '0; Ain_bus = '0; Bin_bus = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_zero_bypass();
        test_cen_throttle();
        test_reset_mid();
        test_req_drop();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
